// File: rtl/apb_bridge_fsm.sv
// APB-side sequencer of the AHB-to-APB bridge: turns decoded AHB beats into APB3 setup/access cycles.
// Latency: read = READ + RENABLE (one AHB wait state); write = WWAIT + WRITE + WENABLE (no wait state).
// Backpressure: Hreadyout=0 stalls the AHB master; with APB_PREADY_EN, Pready=0 holds the access phase.
module apb_bridge_fsm #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NSEL = 3
) (
    input  logic            Hclk,
    input  logic            Hresetn,
    input  logic            valid,
    input  logic            Hwrite,
    input  logic            Hwritereg,
    input  logic [AW-1:0]   Haddr,
    input  logic [AW-1:0]   Haddr1,
    input  logic [AW-1:0]   Haddr2,
    input  logic [DW-1:0]   Hwdata,
`ifdef APB_PREADY_EN
    input  logic            Pready,
`endif
    output logic [NSEL-1:0] Pselx,
    output logic            Penable,
    output logic            Pwrite,
    output logic [AW-1:0]   Paddr,
    output logic [DW-1:0]   Pwdata,
    output logic            Hreadyout
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        WRITE,
        WRITEP,
        RENABLE,
        WENABLE,
        WENABLEP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            hold;
    logic [AW-1:0]   addr_src;
    logic [NSEL-1:0] pselx_nxt;
    logic            penable_nxt;
    logic            pwrite_nxt;
    logic [AW-1:0]   paddr_nxt;
    logic [DW-1:0]   pwdata_nxt;
    logic            hreadyout_nxt;

    // Peripheral i owns the 64 MB window starting at 0x8000_0000 + i*0x0400_0000.
    function automatic logic [NSEL-1:0] dec(input logic [AW-1:0] a);
        logic [NSEL-1:0] s;
        logic [63:0]     lo;
        s = '0;
        for (int i = 0; i < NSEL; i++) begin
            lo = 64'h8000_0000 + 64'(i) * 64'h0400_0000;
            if ((64'(a) >= lo) && (64'(a) < lo + 64'h0400_0000)) begin
                s[i] = 1'b1;
            end
        end
        return s;
    endfunction

    // Next-state selection; an access phase waiting on the slave overrides the table.
    always_comb begin
        state_nxt = state;
        hold      = 1'b0;
        case (state)
            IDLE, RENABLE, WENABLE: begin
                if (valid && !Hwrite)     state_nxt = READ;
                else if (valid && Hwrite) state_nxt = WWAIT;
                else                      state_nxt = IDLE;
            end
            WWAIT:    state_nxt = valid ? WRITEP : WRITE;
            READ:     state_nxt = RENABLE;
            WRITE:    state_nxt = valid ? WENABLEP : WENABLE;
            WRITEP:   state_nxt = WENABLEP;
            WENABLEP: begin
                if (!Hwritereg)  state_nxt = READ;
                else if (valid)  state_nxt = WRITEP;
                else             state_nxt = WRITE;
            end
            default:  state_nxt = IDLE;
        endcase
`ifdef APB_PREADY_EN
        if (((state == RENABLE) || (state == WENABLE) || (state == WENABLEP)) && !Pready) begin
            hold      = 1'b1;
            state_nxt = state;
        end
`endif
    end

    // Output values for the state being entered; anything not listed holds its value.
    // A transfer that follows a pipelined write (from WENABLEP) is two beats old, hence Haddr2.
    always_comb begin
        pselx_nxt     = Pselx;
        penable_nxt   = Penable;
        pwrite_nxt    = Pwrite;
        paddr_nxt     = Paddr;
        pwdata_nxt    = Pwdata;
        hreadyout_nxt = Hreadyout;
        addr_src      = Haddr;
        if (hold) begin
            penable_nxt   = 1'b1;
            hreadyout_nxt = 1'b0;
        end else begin
            case (state_nxt)
                IDLE, WWAIT: begin
                    pselx_nxt     = '0;
                    penable_nxt   = 1'b0;
                    hreadyout_nxt = 1'b1;
                end
                READ: begin
                    addr_src      = (state == WENABLEP) ? Haddr2 : Haddr;
                    paddr_nxt     = addr_src;
                    pselx_nxt     = dec(addr_src);
                    pwrite_nxt    = 1'b0;
                    penable_nxt   = 1'b0;
                    hreadyout_nxt = 1'b0;
                end
                WRITE, WRITEP: begin
                    addr_src      = (state == WENABLEP) ? Haddr2 : Haddr1;
                    paddr_nxt     = addr_src;
                    pselx_nxt     = dec(addr_src);
                    pwdata_nxt    = Hwdata;
                    pwrite_nxt    = 1'b1;
                    penable_nxt   = 1'b0;
                    hreadyout_nxt = (state_nxt == WRITE);
                end
                RENABLE, WENABLE, WENABLEP: begin
                    penable_nxt   = 1'b1;
                    hreadyout_nxt = 1'b1;
                end
                default: begin
                    pselx_nxt     = '0;
                    penable_nxt   = 1'b0;
                    hreadyout_nxt = 1'b1;
                end
            endcase
        end
    end

    // State and registered APB/AHB outputs; reset drops any transfer in flight.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= IDLE;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            state     <= state_nxt;
            Pselx     <= pselx_nxt;
            Penable   <= penable_nxt;
            Pwrite    <= pwrite_nxt;
            Paddr     <= paddr_nxt;
            Pwdata    <= pwdata_nxt;
            Hreadyout <= hreadyout_nxt;
        end
    end

endmodule

// File: tb/tb_apb_bridge_fsm.sv
// Directed bench for apb_bridge_fsm: each step drives one AHB cycle and queues the expected outputs.
// A monitor compares DUT outputs against the queue on every falling edge (or on demand mid-cycle).
// The bench models the slave-interface pipeline (Haddr1/Haddr2/Hwritereg) itself.
module tb_apb_bridge_fsm;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        rdy;
    } exp_t;

    logic        Hclk      = 1'b0;
    logic        Hresetn   = 1'b0;
    logic        valid     = 1'b0;
    logic        Hwrite    = 1'b0;
    logic        Hwritereg = 1'b0;
    logic [31:0] Haddr     = '0;
    logic [31:0] Haddr1    = '0;
    logic [31:0] Haddr2    = '0;
    logic [31:0] Hwdata    = '0;
`ifdef APB_PREADY_EN
    logic        Pready    = 1'b1;
`endif
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;

    exp_t        expq[$];
    int          checks    = 0;
    int          errors    = 0;
    logic        mid_chk_t = 1'b0;

    apb_bridge_fsm #(.AW(32), .DW(32), .NSEL(3)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Hwritereg (Hwritereg),
        .Haddr     (Haddr),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata    (Hwdata),
`ifdef APB_PREADY_EN
        .Pready    (Pready),
`endif
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    always #5 Hclk = ~Hclk;

    // AHB slave-interface pipeline registers feeding the sequencer.
    always @(posedge Hclk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwritereg <= Hwrite;
    end

    // Monitor: pop one expectation per falling edge (or explicit mid-cycle request) and compare.
    always begin
        exp_t e;
        @(negedge Hclk or mid_chk_t);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if ({Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout} !==
                {e.sel, e.en, e.wr, e.addr, e.wdat, e.rdy}) begin
                errors++;
                $display("FAIL %s: got sel=%b en=%b wr=%b addr=%h wdat=%h rdy=%b, expected sel=%b en=%b wr=%b addr=%h wdat=%h rdy=%b",
                         e.name, Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout,
                         e.sel, e.en, e.wr, e.addr, e.wdat, e.rdy);
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [2:0] s, input logic en, input logic wr,
                                input logic [31:0] pa, input logic [31:0] pd, input logic rdy);
        exp_t e;
        e.name = nm; e.sel = s; e.en = en; e.wr = wr; e.addr = pa; e.wdat = pd; e.rdy = rdy;
        return e;
    endfunction

    // Drive one AHB cycle, then queue what the DUT must show after the closing rising edge.
    task automatic step(input logic v, input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                        input string nm, input logic [2:0] s, input logic en, input logic wr,
                        input logic [31:0] pa, input logic [31:0] pd, input logic rdy);
        @(negedge Hclk);
        valid  = v;
        Hwrite = hw;
        Haddr  = ha;
        Hwdata = hd;
        @(posedge Hclk);
        expq.push_back(mk(nm, s, en, wr, pa, pd, rdy));
    endtask

    localparam logic [31:0] A1  = 32'h8000_0010, D1  = 32'hDEAD_BEEF;
    localparam logic [31:0] A2  = 32'h8400_0004;
    localparam logic [31:0] A3A = 32'h8000_0000, D3A = 32'h1111_1111;
    localparam logic [31:0] A3B = 32'h8800_0000, D3B = 32'h2222_2222;
    localparam logic [31:0] AW4 = 32'h8400_0010, DW4 = 32'h3333_3333;
    localparam logic [31:0] AR4 = 32'h8000_0008;
    localparam logic [31:0] X1  = 32'h87FF_FFFC, X2  = 32'h8C00_0000;
    localparam logic [31:0] X3  = 32'h7FFF_FFFC, D5  = 32'h5555_AAAA;
    localparam logic [31:0] A6  = 32'h8000_0020, D6  = 32'h6666_0001;

    initial begin
        // Reset state
        step(0, 0, 0, 0, "reset", 3'b000, 0, 0, 32'h0, 32'h0, 1);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Single write: WWAIT, WRITE, WENABLE, IDLE with no stall
        step(1, 1, A1, 0,  "w1_wwait",  3'b000, 0, 0, 32'h0, 32'h0, 1);
        step(0, 1, 0,  D1, "w1_write",  3'b001, 0, 1, A1, D1, 1);
        step(0, 1, 0,  D1, "w1_enable", 3'b001, 1, 1, A1, D1, 1);
        step(0, 1, 0,  0,  "w1_idle",   3'b000, 0, 1, A1, D1, 1);

        // Single read: one wait state in READ
        step(1, 0, A2, 0, "r2_read",    3'b010, 0, 0, A2, D1, 0);
        step(0, 0, A2, 0, "r2_renable", 3'b010, 1, 0, A2, D1, 1);
        step(0, 0, 0,  0, "r2_idle",    3'b000, 0, 0, A2, D1, 1);

        // Back-to-back writes through the pipelined path
        step(1, 1, A3A, 0,   "b3_wwait",    3'b000, 0, 0, A2,  D1,  1);
        step(1, 1, A3B, D3A, "b3_writep",   3'b001, 0, 1, A3A, D3A, 0);
        step(0, 1, A3B, D3B, "b3_wenablep", 3'b001, 1, 1, A3A, D3A, 1);
        step(0, 1, 0,   D3B, "b3_write",    3'b100, 0, 1, A3B, D3B, 1);
        step(0, 1, 0,   0,   "b3_wenable",  3'b100, 1, 1, A3B, D3B, 1);
        step(0, 0, 0,   0,   "b3_idle",     3'b000, 0, 1, A3B, D3B, 1);

        // Write followed by read: WENABLEP hands over to READ using the delayed address
        step(1, 1, AW4, 0,   "wr4_wwait",    3'b000, 0, 1, A3B, D3B, 1);
        step(1, 0, AR4, DW4, "wr4_writep",   3'b010, 0, 1, AW4, DW4, 0);
        step(0, 0, AR4, DW4, "wr4_wenablep", 3'b010, 1, 1, AW4, DW4, 1);
        step(0, 0, 0,   0,   "wr4_read",     3'b001, 0, 0, AR4, DW4, 0);
        step(0, 0, 0,   0,   "wr4_renable",  3'b001, 1, 0, AR4, DW4, 1);
        step(0, 0, 0,   0,   "wr4_idle",     3'b000, 0, 0, AR4, DW4, 1);

        // Reads at the top of a window and just past the map, chained from RENABLE
        step(1, 0, X1, 0, "rb_read",     3'b010, 0, 0, X1, DW4, 0);
        step(0, 0, X1, 0, "rb_renable",  3'b010, 1, 0, X1, DW4, 1);
        step(1, 0, X2, 0, "rb_read2",    3'b000, 0, 0, X2, DW4, 0);
        step(0, 0, X2, 0, "rb_renable2", 3'b000, 1, 0, X2, DW4, 1);
        step(0, 0, 0,  0, "rb_idle",     3'b000, 0, 0, X2, DW4, 1);

        // Write just below the map: sequence runs with no select
        step(1, 1, X3, 0,  "wo_wwait",   3'b000, 0, 0, X2, DW4, 1);
        step(0, 1, 0,  D5, "wo_write",   3'b000, 0, 1, X3, D5,  1);
        step(0, 1, 0,  0,  "wo_wenable", 3'b000, 1, 1, X3, D5,  1);
        step(0, 0, 0,  0,  "wo_idle",    3'b000, 0, 1, X3, D5,  1);

        // Asynchronous reset in the middle of WRITE
        step(1, 1, A6, 0,  "rs_wwait", 3'b000, 0, 1, X3, D5, 1);
        step(0, 1, 0,  D6, "rs_write", 3'b001, 0, 1, A6, D6, 1);
        @(negedge Hclk);
        #2;
        Hresetn = 1'b0;
        #1;
        expq.push_back(mk("rs_async", 3'b000, 0, 0, 32'h0, 32'h0, 1));
        mid_chk_t = ~mid_chk_t;
        step(0, 0, 0, 0, "rs_hold", 3'b000, 0, 0, 32'h0, 32'h0, 1);
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Normal operation resumes after reset
        step(1, 0, A2, 0, "pr_read",    3'b010, 0, 0, A2, 32'h0, 0);
        step(0, 0, A2, 0, "pr_renable", 3'b010, 1, 0, A2, 32'h0, 1);
        step(0, 0, 0,  0, "pr_idle",    3'b000, 0, 0, A2, 32'h0, 1);

`ifdef APB_PREADY_EN
        // Slow slave: Pready low for three access cycles
        step(1, 0, A2, 0, "p5_read", 3'b010, 0, 0, A2, 32'h0, 0);
        Pready = 1'b0;
        step(0, 0, A2, 0, "p5_renable", 3'b010, 1, 0, A2, 32'h0, 1);
        step(0, 0, A2, 0, "p5_hold1",   3'b010, 1, 0, A2, 32'h0, 0);
        step(0, 0, A2, 0, "p5_hold2",   3'b010, 1, 0, A2, 32'h0, 0);
        step(0, 0, A2, 0, "p5_hold3",   3'b010, 1, 0, A2, 32'h0, 0);
        Pready = 1'b1;
        step(0, 0, 0,  0, "p5_idle",    3'b000, 0, 0, A2, 32'h0, 1);
`endif

        repeat (2) @(negedge Hclk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
